// File: rtl/rocket_datapath.sv
// Rocket datapath: holds the rocket column and streams pixels to the VGA
// adapter for full-screen clears and homebase-band redraws, returning level
// handshakes to the controlling FSM.
module rocket_datapath #(
  parameter int       SCREEN_W      = 160,
  parameter int       SCREEN_H      = 120,
  parameter int       ROCKET_W      = 8,
  parameter int       ROCKET_H      = 4,
  parameter int       BASE_Y        = 112,
  parameter int       STEP          = 2,
  parameter int       START_X       = 76,
  parameter logic [2:0] ROCKET_COLOUR = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       screen_clear_en,
  input  logic       left_en,
  input  logic       right_en,
  input  logic       draw_en,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       screen_cleared,
  output logic       drew_homebase,
  output logic [7:0] rocket_x
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLEAR      = 3'd1,
    CLEAR_DONE = 3'd2,
    DRAW       = 3'd3,
    DRAW_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] X_LAST    = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST    = 7'(SCREEN_H - 1);
  localparam logic [6:0] BAND_TOP  = 7'(BASE_Y);
  localparam logic [6:0] BAND_LAST = 7'(BASE_Y + ROCKET_H - 1);
  localparam logic [8:0] X_MAX     = 9'(SCREEN_W - ROCKET_W);
  localparam logic [8:0] STEP_W    = 9'(STEP);
  localparam logic [8:0] WIDTH_W   = 9'(ROCKET_W);
  localparam logic [7:0] START_POS = 8'(START_X);

  state_t     state_r, state_next_s;
  logic [7:0] cx_r, cx_next_s;
  logic [6:0] cy_r, cy_next_s;
  logic [7:0] rocket_x_r, rocket_x_next_s;
  logic [8:0] rocket_x_wide_s;
  logic       plot_next_s;
  logic [2:0] colour_next_s;

  logic [7:0] x_out_r;
  logic [6:0] y_out_r;
  logic [2:0] colour_r;
  logic       plot_r;
  logic       screen_cleared_r;
  logic       drew_homebase_r;

  // Column test done at 9 bits so rocket_x + ROCKET_W never wraps.
  function automatic logic in_rocket(input logic [7:0] col, input logic [7:0] left);
    logic [8:0] col_w;
    logic [8:0] left_w;
    col_w  = {1'b0, col};
    left_w = {1'b0, left};
    return (col_w >= left_w) && (col_w < (left_w + WIDTH_W));
  endfunction

  // Next-state, sweep counters and rocket movement.
  always_comb begin
    state_next_s    = state_r;
    cx_next_s       = cx_r;
    cy_next_s       = cy_r;
    rocket_x_next_s = rocket_x_r;
    rocket_x_wide_s = {1'b0, rocket_x_r};
    case (state_r)
      IDLE: begin
        if (screen_clear_en) begin
          state_next_s = CLEAR;
          cx_next_s    = 8'd0;
          cy_next_s    = 7'd0;
        end else if (draw_en) begin
          state_next_s = DRAW;
          cx_next_s    = 8'd0;
          cy_next_s    = BAND_TOP;
        end else if (left_en && !right_en) begin
          if (rocket_x_wide_s < STEP_W) begin
            rocket_x_next_s = 8'd0;
          end else begin
            rocket_x_next_s = 8'(rocket_x_wide_s - STEP_W);
          end
        end else if (right_en && !left_en) begin
          if ((rocket_x_wide_s + STEP_W) > X_MAX) begin
            rocket_x_next_s = X_MAX[7:0];
          end else begin
            rocket_x_next_s = 8'(rocket_x_wide_s + STEP_W);
          end
        end else begin
          rocket_x_next_s = rocket_x_r;
        end
      end
      CLEAR: begin
        if (cx_r == X_LAST) begin
          cx_next_s = 8'd0;
          if (cy_r == Y_LAST) begin
            cy_next_s    = 7'd0;
            state_next_s = CLEAR_DONE;
          end else begin
            cy_next_s = cy_r + 7'd1;
          end
        end else begin
          cx_next_s = cx_r + 8'd1;
        end
      end
      CLEAR_DONE: begin
        if (!screen_clear_en) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = CLEAR_DONE;
        end
      end
      DRAW: begin
        if (cx_r == X_LAST) begin
          cx_next_s = 8'd0;
          if (cy_r == BAND_LAST) begin
            cy_next_s    = 7'd0;
            state_next_s = DRAW_DONE;
          end else begin
            cy_next_s = cy_r + 7'd1;
          end
        end else begin
          cx_next_s = cx_r + 8'd1;
        end
      end
      DRAW_DONE: begin
        if (!draw_en) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DRAW_DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
        cx_next_s    = 8'd0;
        cy_next_s    = 7'd0;
      end
    endcase
  end

  // Pixel tuple for the upcoming state, so outputs line up with the state register.
  always_comb begin
    plot_next_s   = (state_next_s == CLEAR) || (state_next_s == DRAW);
    colour_next_s = 3'b000;
    if ((state_next_s == DRAW) && in_rocket(cx_next_s, rocket_x_next_s)) begin
      colour_next_s = ROCKET_COLOUR;
    end else begin
      colour_next_s = 3'b000;
    end
  end

  // State, counters, rocket position and registered VGA/handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= IDLE;
      cx_r             <= 8'd0;
      cy_r             <= 7'd0;
      rocket_x_r       <= START_POS;
      x_out_r          <= 8'd0;
      y_out_r          <= 7'd0;
      colour_r         <= 3'b000;
      plot_r           <= 1'b0;
      screen_cleared_r <= 1'b0;
      drew_homebase_r  <= 1'b0;
    end else begin
      state_r          <= state_next_s;
      cx_r             <= cx_next_s;
      cy_r             <= cy_next_s;
      rocket_x_r       <= rocket_x_next_s;
      x_out_r          <= cx_next_s;
      y_out_r          <= cy_next_s;
      colour_r         <= colour_next_s;
      plot_r           <= plot_next_s;
      screen_cleared_r <= (state_next_s == CLEAR_DONE);
      drew_homebase_r  <= (state_next_s == DRAW_DONE);
    end
  end

  assign x_out          = x_out_r;
  assign y_out          = y_out_r;
  assign colour         = colour_r;
  assign plot           = plot_r;
  assign screen_cleared = screen_cleared_r;
  assign drew_homebase  = drew_homebase_r;
  assign rocket_x       = rocket_x_r;

endmodule

// File: tb/tb_rocket_datapath.sv
// Bench for rocket_datapath: directed sequence with an expected-pixel queue.
module tb_rocket_datapath;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       screen_clear_en = 1'b0;
  logic       left_en = 1'b0;
  logic       right_en = 1'b0;
  logic       draw_en = 1'b0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic       screen_cleared;
  logic       drew_homebase;
  logic [7:0] rocket_x;

  rocket_datapath dut (
    .clk(clk), .reset(reset), .screen_clear_en(screen_clear_en),
    .left_en(left_en), .right_en(right_en), .draw_en(draw_en),
    .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot),
    .screen_cleared(screen_cleared), .drew_homebase(drew_homebase),
    .rocket_x(rocket_x)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   model_rx = 76;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_sweep(input int y0, input int rows, input int rx, input bit is_draw);
    for (int y = y0; y < y0 + rows; y++) begin
      for (int x = 0; x < 160; x++) begin
        pix_t p;
        p.x = 8'(x);
        p.y = 7'(y);
        p.c = (is_draw && x >= rx && x < rx + 8) ? 3'b010 : 3'b000;
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic drain(input string tag, input int budget, input int left_at);
    int   k;
    int   n;
    int   expected_n;
    pix_t got;
    pix_t want;
    k = 0;
    n = 0;
    expected_n = exp_q.size();
    while (exp_q.size() > 0 && k < budget) begin
      left_en = (k == left_at);
      tick();
      k++;
      if (plot) begin
        got  = {x_out, y_out, colour};
        want = exp_q.pop_front();
        n++;
        check({tag, " pixel"}, 32'(got), 32'(want));
      end
    end
    left_en = 1'b0;
    check({tag, " plot count"}, 32'(n), 32'(expected_n));
    exp_q.delete();
  endtask

  task automatic step_model(input bit l, input bit r);
    if (l && !r) model_rx = (model_rx < 2) ? 0 : model_rx - 2;
    else if (r && !l) model_rx = (model_rx + 2 > 152) ? 152 : model_rx + 2;
  endtask

  task automatic move(input bit l, input bit r);
    left_en  = l;
    right_en = r;
    tick();
    left_en  = 1'b0;
    right_en = 1'b0;
    step_model(l, r);
    check("move", 32'(rocket_x), 32'(model_rx));
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check("rst rocket_x", 32'(rocket_x), 32'd76);
    check("rst plot", 32'(plot), 32'd0);
    check("rst cleared", 32'(screen_cleared), 32'd0);
    check("rst drew", 32'(drew_homebase), 32'd0);
    check("rst x_out", 32'(x_out), 32'd0);
    reset = 1'b0;
    tick();

    // Reset in the middle of a clear
    screen_clear_en = 1'b1;
    repeat (10) tick();
    check("mid clear plot", 32'(plot), 32'd1);
    check("mid clear x", 32'(x_out), 32'd9);
    reset = 1'b1;
    screen_clear_en = 1'b0;
    tick();
    check("midrst plot", 32'(plot), 32'd0);
    check("midrst rocket_x", 32'(rocket_x), 32'd76);
    check("midrst x_out", 32'(x_out), 32'd0);
    check("midrst y_out", 32'(y_out), 32'd0);
    reset = 1'b0;
    tick();
    check("post rst idle plot", 32'(plot), 32'd0);

    // Full clear
    screen_clear_en = 1'b1;
    push_sweep(0, 120, 0, 1'b0);
    drain("clear", 19300, -1);
    tick();
    check("clear done plot", 32'(plot), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("clear hold cleared", 32'(screen_cleared), 32'd1);
      check("clear hold no plot", 32'(plot), 32'd0);
      tick();
    end
    screen_clear_en = 1'b0;
    tick();
    check("clear release", 32'(screen_cleared), 32'd0);
    check("clear release plot", 32'(plot), 32'd0);

    // Movement
    model_rx = 76;
    move(1'b0, 1'b1);
    check("right once", 32'(rocket_x), 32'd78);
    right_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      step_model(1'b0, 1'b1);
      check("right hold", 32'(rocket_x), 32'(model_rx));
    end
    right_en = 1'b0;
    check("right clamp", 32'(rocket_x), 32'd152);
    left_en = 1'b1;
    for (int i = 0; i < 75; i++) begin
      tick();
      step_model(1'b1, 1'b0);
    end
    left_en = 1'b0;
    check("left to 2", 32'(rocket_x), 32'd2);
    move(1'b1, 1'b0);
    check("left floor", 32'(rocket_x), 32'd0);
    move(1'b1, 1'b0);
    check("left floor again", 32'(rocket_x), 32'd0);
    move(1'b1, 1'b1);
    check("both", 32'(rocket_x), 32'd0);
    for (int i = 0; i < 39; i++) move(1'b0, 1'b1);
    check("back to 78", 32'(rocket_x), 32'd78);

    // Homebase draw at 78
    draw_en = 1'b1;
    push_sweep(112, 4, 78, 1'b1);
    drain("draw", 700, -1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("draw hold drew", 32'(drew_homebase), 32'd1);
      check("draw hold plot", 32'(plot), 32'd0);
      tick();
    end
    draw_en = 1'b0;
    tick();
    check("draw release", 32'(drew_homebase), 32'd0);

    // Clear has priority, then draw follows
    screen_clear_en = 1'b1;
    draw_en = 1'b1;
    push_sweep(0, 120, 0, 1'b0);
    drain("prio clear", 19300, -1);
    tick();
    check("prio cleared", 32'(screen_cleared), 32'd1);
    screen_clear_en = 1'b0;
    push_sweep(112, 4, 78, 1'b1);
    drain("prio draw", 700, -1);
    tick();
    check("prio drew", 32'(drew_homebase), 32'd1);
    draw_en = 1'b0;
    tick();
    check("prio drew release", 32'(drew_homebase), 32'd0);

    // Left pulse during draw is ignored
    draw_en = 1'b1;
    push_sweep(112, 4, 78, 1'b1);
    drain("draw left", 700, 100);
    check("draw left rx", 32'(rocket_x), 32'd78);
    tick();
    check("draw left drew", 32'(drew_homebase), 32'd1);
    draw_en = 1'b0;
    tick();
    left_en = 1'b1;
    tick();
    left_en = 1'b0;
    check("idle left after draw", 32'(rocket_x), 32'd76);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
